pwm_ramp_ctr: RTL

Soft-start / fade controller for the team's 13-bit PWM at 5 MHz (period 5000 clocks = 1 kHz).
- Accepts a target duty through a valid/ready handshake.
- Steps the live duty toward the target by a programmable increment every N PWM periods, changing duty only at period boundaries.
- Drives pwm_out plus the live duty value, so upstream logic (VIO, CPU, sequencer) never causes glitched or mid-period duty changes.

---
 rtl/pwm_pkg.sv | 50 +++++
 rtl/pwm_ramp_ctr_if.sv | 17 +
 rtl/pwm_core.sv | 34 +++
 rtl/pwm_ramp_ctr.sv | 119 +++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants, FSM encoding and duty arithmetic helpers for the PWM
// soft-start / fade controller.
package pwm_pkg;

    localparam int CNT_W          = 13;
    localparam int PERIOD_DEFAULT = 5000;
    localparam int HOLD_W         = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_t;

    // Limit a requested duty to the period length (anything above is "always high").
    function automatic logic [CNT_W-1:0] clamp_duty(input logic [CNT_W-1:0] d,
                                                   input logic [CNT_W-1:0] lim);
        return (d > lim) ? lim : d;
    endfunction

    // A zero step size is treated as one.
    function automatic logic [CNT_W-1:0] min1_step(input logic [CNT_W-1:0] s);
        return (s == '0) ? CNT_W'(1) : s;
    endfunction

    // A zero hold count is treated as one period per step.
    function automatic logic [HOLD_W-1:0] min1_hold(input logic [HOLD_W-1:0] h);
        return (h == '0) ? HOLD_W'(1) : h;
    endfunction

    // Upward step saturating at the target; the sum uses one spare bit so it cannot wrap.
    function automatic logic [CNT_W-1:0] step_up(input logic [CNT_W-1:0] cur,
                                                input logic [CNT_W-1:0] step,
                                                input logic [CNT_W-1:0] tgt);
        logic [CNT_W:0] sum;
        sum = {1'b0, cur} + {1'b0, step};
        return (sum >= {1'b0, tgt}) ? tgt : sum[CNT_W-1:0];
    endfunction

    // Downward step saturating at the target; never subtracts past zero.
    function automatic logic [CNT_W-1:0] step_down(input logic [CNT_W-1:0] cur,
                                                  input logic [CNT_W-1:0] step,
                                                  input logic [CNT_W-1:0] tgt);
        logic [CNT_W-1:0] diff;
        diff = cur - step;
        if (cur > step) return (diff < tgt) ? tgt : diff;
        return tgt;
    endfunction

endpackage

// File: rtl/pwm_ramp_ctr_if.sv
// Ramp request channel. Valid/ready semantics: the requester raises tgt_valid
// with stable tgt_duty/tgt_step/tgt_hold and keeps all of them unchanged until
// a rising clk_in edge where tgt_valid and tgt_ready are both 1; that edge is
// the transfer. tgt_ready may drop at any time and never depends on tgt_valid.
interface pwm_ramp_ctr_if #(
    parameter int CNT_W  = pwm_pkg::CNT_W,
    parameter int HOLD_W = pwm_pkg::HOLD_W
);
    logic              tgt_valid;
    logic              tgt_ready;
    logic [CNT_W-1:0]  tgt_duty;
    logic [CNT_W-1:0]  tgt_step;
    logic [HOLD_W-1:0] tgt_hold;

    modport master (output tgt_valid, tgt_duty, tgt_step, tgt_hold, input tgt_ready);
    modport slave  (input tgt_valid, tgt_duty, tgt_step, tgt_hold, output tgt_ready);
endinterface

// File: rtl/pwm_core.sv
// PWM period counter with registered compare output and period markers.
module pwm_core #(
    parameter int CNT_W  = 13,
    parameter int PERIOD = 5000
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [CNT_W-1:0] duty,
    output logic             pwm_out,
    output logic             period_start,
    output logic             last_cycle
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] cnt;

    // Last clock of a running period; the ramp FSM only moves duty here.
    assign last_cycle = enable & (cnt == LAST);

    // Counter runs 0..PERIOD-1 while enabled, parks at 0 otherwise; compare is registered.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            cnt          <= '0;
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
        end else begin
            pwm_out      <= enable & (cnt < duty);
            period_start <= last_cycle;
            if (!enable || cnt == LAST) cnt <= '0;
            else                        cnt <= cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/pwm_ramp_ctr.sv
// Soft-start / fade controller: accepts a target duty and walks the live duty
// toward it in steps, only ever changing duty at PWM period boundaries.
module pwm_ramp_ctr #(
    parameter int CNT_W        = pwm_pkg::CNT_W,
    parameter int PERIOD       = pwm_pkg::PERIOD_DEFAULT,
    parameter int HOLD_W       = pwm_pkg::HOLD_W,
    parameter int DEFAULT_DUTY = 0
) (
    input  logic               clk_in,
    input  logic               rst_n,
    input  logic               enable,
    pwm_ramp_ctr_if.slave      req,
    output logic               pwm_out,
    output logic [CNT_W-1:0]   duty_cur,
    output logic               period_start,
    output logic               busy,
    output logic               done,
    output pwm_pkg::state_t    state
);
    import pwm_pkg::*;

    localparam logic [CNT_W-1:0] PERIOD_C = CNT_W'(PERIOD);

    logic [CNT_W-1:0]  tgt, step, in_tgt, in_step, s_tgt, s_step, stepped;
    logic [HOLD_W-1:0] hold, hold_cnt, in_hold, s_hold, s_hcnt;
    logic              live, last_cycle, accept, s_up, step_due;

    pwm_core #(.CNT_W(CNT_W), .PERIOD(PERIOD)) u_core (
        .clk_in       (clk_in),
        .rst_n        (rst_n),
        .enable       (enable),
        .duty         (duty_cur),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .last_cycle   (last_cycle)
    );

    assign in_tgt        = clamp_duty(req.tgt_duty, PERIOD_C);
    assign in_step       = min1_step(req.tgt_step);
    assign in_hold       = min1_hold(req.tgt_hold);
    // live keeps ready low on the first cycle after reset release.
    assign req.tgt_ready = enable & live & (state == IDLE) & ~done;
    assign accept        = req.tgt_valid & req.tgt_ready;
    assign busy          = (state != IDLE);

    // Step operands: freshly accepted fields on the accept cycle, latched ones while ramping.
    always_comb begin
        s_tgt  = tgt;
        s_step = step;
        s_hold = hold;
        s_hcnt = hold_cnt;
        s_up   = (state == UP);
        if (accept) begin
            s_tgt  = in_tgt;
            s_step = in_step;
            s_hold = in_hold;
            s_hcnt = '0;
            s_up   = (in_tgt > duty_cur);
        end
        stepped  = s_up ? step_up(duty_cur, s_step, s_tgt) : step_down(duty_cur, s_step, s_tgt);
        step_due = (s_hcnt == s_hold - HOLD_W'(1));
    end

    // Ramp FSM: latches requests, counts held periods and applies steps at boundaries.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state    <= IDLE;
            duty_cur <= CNT_W'(DEFAULT_DUTY);
            hold_cnt <= '0;
            done     <= 1'b0;
            live     <= 1'b0;
            tgt      <= '0;
            step     <= CNT_W'(1);
            hold     <= HOLD_W'(1);
        end else begin
            live <= 1'b1;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        tgt      <= in_tgt;
                        step     <= in_step;
                        hold     <= in_hold;
                        hold_cnt <= '0;
                        if (in_tgt == duty_cur) begin
                            done <= 1'b1;
                        end else if (last_cycle && step_due) begin
                            // Accepted on a boundary with hold 1: that boundary is the first step.
                            duty_cur <= stepped;
                            if (stepped == in_tgt) done  <= 1'b1;
                            else                   state <= s_up ? UP : DOWN;
                        end else begin
                            state <= s_up ? UP : DOWN;
                            if (last_cycle) hold_cnt <= HOLD_W'(1);
                        end
                    end
                end
                UP, DOWN: begin
                    if (!enable) begin
                        state    <= IDLE;
                        hold_cnt <= '0;
                    end else if (last_cycle) begin
                        if (!step_due) begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end else begin
                            hold_cnt <= '0;
                            duty_cur <= stepped;
                            if (stepped == tgt) begin
                                state <= IDLE;
                                done  <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
